// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, default reset PC and FSM encoding for the fetch unit
package ifetch_pkg;
   localparam int ADDR_W = 64;
   localparam int INSTR_W = 32;
   localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;
   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t RUN = 1'b1;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetched {pc, instruction} pairs with flush
module fetch_buffer
   import ifetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               flush_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic [1:0]         count_o,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o
);
   logic [ADDR_W-1:0]  pc_q [2];
   logic [INSTR_W-1:0] instr_q [2];
   logic               head_q, head_d, tail;
   logic [1:0]         count_q, count_d;
   // Tail wraps onto the head slot when full; a full push is only allowed alongside a pop.
   assign tail = head_q ^ count_q[0];
   assign count_o = count_q;
   assign head_pc_o = pc_q[head_q];
   assign head_instr_o = instr_q[head_q];
   always_comb begin
      count_d = flush_i ? 2'd0 : count_q + {1'b0, push_i} - {1'b0, pop_i};
      head_d = flush_i ? head_q : head_q ^ pop_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '{default: '0};
         instr_q <= '{default: '0};
         head_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         head_q <= head_d;
         count_q <= count_d;
         if (push_i) begin
            pc_q[tail] <= pc_i;
            instr_q[tail] <= instr_i;
         end
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, run/idle FSM and decode handshake over a 2-entry buffer
module instruction_fetch
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter int BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   output logic [ADDR_W-1:0]  ReadAddr,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        count;
   logic              pop, push;
   if (BUF_DEPTH != 2) begin : g_depth_check
      $error("instruction_fetch: BUF_DEPTH must be 2");
   end
   assign ReadAddr = pc_q;
   assign out_valid = count != 2'd0;
   assign pop = out_valid & out_ready;
   assign push = state_q == RUN && !branch_valid && (count != 2'd2 || pop);
   always_comb begin
      state_d = fetch_en ? RUN : IDLE;
      pc_d = branch_valid ? branch_target & ~ADDR_W'(3) : push ? pc_q + ADDR_W'(4) : pc_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
      end
   end
   fetch_buffer u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (branch_valid),
      .pc_i        (pc_q),
      .instr_i     (Instruction),
      .count_o     (count),
      .head_pc_o   (out_pc),
      .head_instr_o(out_instr)
   );
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the PC value loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of fetched-instruction buffer entries; the only supported value is 2.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 fetch_en  input  1  is the run request; 1 means fetch, 0 means hold the PC and drain.
REQ-006 ReadAddr  output  64  is the byte address to instruction memory; it SHALL equal the PC register combinationally.
REQ-007 Instruction  input  32  is the memory read data; it is combinational from ReadAddr in the same cycle.
REQ-008 branch_valid  input  1  is the redirect request, valid for one cycle.
REQ-009 branch_target  input  64  is the redirect byte address.
REQ-010 out_valid  output  1  means the head buffer entry is presented to decode.
REQ-011 out_ready  input  1  means decode accepts the head entry this cycle.
REQ-012 out_instr  output  32  is the head entry instruction word.
REQ-013 out_pc  output  64  is the head entry PC.

Function
REQ-014 FSM states: IDLE and RUN.
REQ-015 IDLE->RUN SHALL occur at an edge with fetch_en=1; RUN->IDLE SHALL occur at an edge with fetch_en=0.
REQ-016 pop SHALL equal out_valid AND out_ready.
REQ-017 push SHALL equal state==RUN AND NOT branch_valid AND (count<2 OR pop).
REQ-018 On push, {PC, Instruction} SHALL be written to the buffer tail and PC SHALL become PC+4, with modulo-2^64 wrap.
REQ-019 count SHALL be updated as count + push - pop; a simultaneous push and pop at count=2 SHALL keep count=2 with no loss.
REQ-020 out_valid SHALL be (count!=0), out_instr/out_pc SHALL be the head entry, and all three SHALL be taken from registers only.
REQ-021 The entry order SHALL be FIFO, and no entry SHALL be duplicated or dropped except by a flush.
REQ-022 branch_valid=1 at an edge SHALL set count to 0, discard any coincident pop, and suppress the push.
REQ-023 branch_valid=1 at an edge SHALL load PC with {branch_target[63:2],2'b00} in either state.
REQ-024 Redirect-to-delivery latency: branch at edge k; first target instruction pushed at edge k+1; out_valid=1 after edge k+1.
REQ-025 Start latency: fetch_en seen at edge k; first push at edge k+1.
REQ-026 In IDLE, the PC SHALL be held, no push SHALL occur, and existing entries SHALL continue draining via pop.
REQ-027 out_valid=1 with out_ready=0 SHALL hold out_instr/out_pc stable until pop or flush.

Reset
REQ-028 While rst_n=0: PC=RESET_PC, state=IDLE, count=0, buffer entries=0.
REQ-029 While rst_n=0: out_valid=0, out_instr=32'h0, out_pc=64'h0, ReadAddr=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-031 The first edge after rst_n rises SHALL be treated as a normal edge.

Structure
REQ-032 Shared package ifetch_pkg SHALL hold ADDR_W=64, INSTR_W=32, the default RESET_PC, and the FSM state encoding typedef.
REQ-033 Sub-module fetch_buffer SHALL implement the 2-entry FIFO: push, pop, flush, count, head data.
REQ-034 PC, FSM and handshake logic SHALL reside in instruction_fetch.

Verification
Bench memory image: words 0-3 = 8b1f03e5, f84000a4, 8b040086, f80010a6.
REQ-035 Reset, fetch_en=1, out_ready=1 -> out_valid from 2nd edge; (pc,instr) stream (0,8b1f03e5),(4,f84000a4),(8,8b040086),(C,f80010a6), one per cycle.
REQ-036 out_ready=0 for 5 cycles -> count saturates at 2 and ReadAddr holds 0x8; release -> 8b1f03e5 then f84000a4 with no gap, no loss.
REQ-037 Branch to 0xE (misaligned) while 2 entries buffered and out_ready=1 -> buffer flushed, next out_pc=0xC, out_instr=f80010a6.
REQ-038 fetch_en drops after 2 pushes with out_ready=0 -> ReadAddr frozen at 0x8; raising out_ready drains exactly 2 entries, then out_valid=0.
REQ-039 rst_n pulsed low mid-stream (between edges) -> out_valid=0 and ReadAddr=0 immediately; after release, the stream restarts at pc 0.
REQ-040 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC with 2 pushes -> out_pc sequence FFFF_FFFF_FFFF_FFFC then 0.
